// File: rtl/snn_pkg.sv
// Shared widths, state encoding and saturating arithmetic for the SNN datapath.
package snn_pkg;

    localparam int unsigned Q_W   = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_CALC,
        ST_EMIT,
        ST_NEXT,
        ST_DONE
    } lif_state_e;

    // Signed add in 33 bits, clamped back into the Q16.16 range.
    function automatic logic signed [Q_W-1:0] sat_add33(
        input logic signed [Q_W-1:0] a,
        input logic signed [Q_W-1:0] b
    );
        logic signed [Q_W:0] s;
        s = {a[Q_W-1], a} + {b[Q_W-1], b};
        if (s[Q_W] != s[Q_W-1]) begin
            return s[Q_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
        return s[Q_W-1:0];
    endfunction

endpackage

// File: rtl/lif_update_comb.sv
// Leak, integrate, saturate and threshold for one neuron; purely combinational.
module lif_update_comb
    import snn_pkg::*;
#(
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic signed [Q_W-1:0] v,
    input  logic signed [Q_W-1:0] i_post,
    input  logic signed [Q_W-1:0] thr,
    input  logic signed [Q_W-1:0] vr,
    output logic signed [Q_W-1:0] v_new,
    output logic                  spike
);

    logic signed [Q_W-1:0] leak;
    logic signed [Q_W-1:0] decayed;
    logic signed [Q_W-1:0] sum_sat;

    // V - V/2^k cannot overflow (same sign, smaller magnitude); only the add saturates.
    always_comb begin
        leak    = v >>> LEAK_SHIFT;
        decayed = v - leak;
        sum_sat = sat_add33(decayed, i_post);
        spike   = (sum_sat >= thr);
        v_new   = spike ? vr : sum_sat;
    end

endmodule

// File: rtl/lif_neuron_sweep.sv
// Per-timestep LIF sweep: read I_post/V, update V, clear I_post, emit spikes.
module lif_neuron_sweep
    import snn_pkg::*;
#(
    parameter int unsigned N_NEURON   = 4096,
    parameter int unsigned ADDRW      = 12,
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step,
    input  logic [Q_W-1:0]    i_thresh,
    input  logic [Q_W-1:0]    i_v_reset,
    output logic              o_busy,
    output logic              o_step_done,
    output logic [CNT_W-1:0]  o_spike_count,
    output logic [ADDRW-1:0]  o_i_addr,
    output logic              o_i_we,
    output logic [Q_W-1:0]    o_i_din,
    input  logic [Q_W-1:0]    i_i_dout,
    output logic [ADDRW-1:0]  o_v_addr,
    output logic              o_v_we,
    output logic [Q_W-1:0]    o_v_din,
    input  logic [Q_W-1:0]    i_v_dout,
    output logic              o_spike_valid,
    output logic [CNT_W-1:0]  o_spike_idx,
    input  logic              i_spike_ready
);

    lif_state_e       state, state_next;
    logic [ADDRW-1:0] n;
    logic [Q_W-1:0]   thr_q, vr_q;
    logic             spike_q;
    logic [CNT_W-1:0] step_cnt;
    logic             last;

    logic [Q_W-1:0]   v_new;
    logic             spike;

    logic             busy_d, v_we_d, i_we_d, valid_d, done_d;

    assign last        = (n == ADDRW'(N_NEURON - 1));
    assign o_i_addr    = n;
    assign o_v_addr    = n;
    assign o_spike_idx = CNT_W'(n);
    assign o_i_din     = '0;

    lif_update_comb #(.LEAK_SHIFT(LEAK_SHIFT)) u_update (
        .v      (i_v_dout),
        .i_post (i_i_dout),
        .thr    (thr_q),
        .vr     (vr_q),
        .v_new  (v_new),
        .spike  (spike)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_step) state_next = ST_READ;
            ST_READ: state_next = ST_WAIT;
            ST_WAIT: state_next = ST_CALC;
            ST_CALC: state_next = spike_q ? ST_EMIT : ST_NEXT;
            ST_EMIT: if (i_spike_ready) state_next = ST_NEXT;
            ST_NEXT: state_next = last ? ST_DONE : ST_READ;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the output registers align with it.
    always_comb begin
        busy_d  = 1'b0;
        v_we_d  = 1'b0;
        i_we_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_next)
            ST_READ, ST_WAIT, ST_NEXT: busy_d = 1'b1;
            ST_CALC: begin
                busy_d = 1'b1;
                v_we_d = 1'b1;
                i_we_d = 1'b1;
            end
            ST_EMIT: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Sweep index, sampled parameters, spike decision and per-step spike counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= '0;
            thr_q    <= '0;
            vr_q     <= '0;
            spike_q  <= 1'b0;
            step_cnt <= '0;
        end else begin
            if (state == ST_IDLE && i_step) begin
                n        <= '0;
                thr_q    <= i_thresh;
                vr_q     <= i_v_reset;
                step_cnt <= '0;
            end
            if (state == ST_WAIT) spike_q <= spike;
            if (state == ST_EMIT && i_spike_ready && step_cnt != {CNT_W{1'b1}})
                step_cnt <= step_cnt + CNT_W'(1);
            if (state == ST_NEXT && !last) n <= n + ADDRW'(1);
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_busy        <= 1'b0;
            o_step_done   <= 1'b0;
            o_spike_count <= '0;
            o_i_we        <= 1'b0;
            o_v_we        <= 1'b0;
            o_v_din       <= '0;
            o_spike_valid <= 1'b0;
        end else begin
            o_busy        <= busy_d;
            o_step_done   <= done_d;
            o_i_we        <= i_we_d;
            o_v_we        <= v_we_d;
            o_spike_valid <= valid_d;
            if (state == ST_WAIT) o_v_din <= v_new;
            if (done_d)           o_spike_count <= step_cnt;
        end
    end

endmodule
